load_align_unit: RTL

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

---
 rtl/load_align_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/load_align_unit.sv
// Load alignment unit: fetches one or two bus beats for a byte/half/word/double
// load, merges and shifts them into place, then sign- or zero-extends the result.
module load_align_unit #(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [4:0]      req_tag,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic [XLEN-1:0] bus_addr,
  input  logic            bus_rsp_valid,
  input  logic [XLEN-1:0] bus_rsp_data,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_tag,
  output logic            resp_fault
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        op_reg;
  logic [XLEN-1:0]   addr_reg;
  logic [4:0]        tag_reg;
  logic [XLEN-1:0]   beat0_reg;
  logic [XLEN-1:0]   resp_data_reg;
  logic              resp_fault_reg;

  // True when an access of 2^size bytes at this beat offset spills into the next beat.
  function automatic logic crosses(input logic [1:0] size, input logic [OFFW-1:0] off);
    logic [4:0] sum;
    sum = 5'(off) + (5'd1 << size);
    return sum > 5'(NB);
  endfunction

  logic req_illegal;
  logic lat_cross;
  assign req_illegal = (XLEN == 32 && req_op[1:0] == 2'b11) ||
                       (!ALLOW_MISALIGNED && crosses(req_op[1:0], req_addr[OFFW-1:0]));
  assign lat_cross   = crosses(op_reg[1:0], addr_reg[OFFW-1:0]);

  logic [XLEN-1:0]   beat_addr;
  assign beat_addr = addr_reg & ~XLEN'(NB - 1);

  // In WAIT1 the first beat comes from the holding register and the live beat is the upper half.
  logic [XLEN-1:0]   merge_lo, merge_hi, merge_data;
  logic [2*XLEN-1:0] shifted;
  logic [3:0]        size_bytes;
  logic              sign_bit, fill_bit;

  assign merge_lo   = (state_reg == WAIT1) ? beat0_reg : bus_rsp_data;
  assign merge_hi   = (state_reg == WAIT1) ? bus_rsp_data : '0;
  assign shifted    = {merge_hi, merge_lo} >> {addr_reg[OFFW-1:0], 3'b000};
  assign size_bytes = 4'd1 << op_reg[1:0];

  always_comb begin
    sign_bit = shifted[7];
    case (op_reg[1:0])
      2'b01:   sign_bit = shifted[15];
      2'b10:   sign_bit = shifted[31];
      2'b11:   sign_bit = shifted[63];
      default: sign_bit = shifted[7];
    endcase
  end

  assign fill_bit = ~op_reg[2] & sign_bit;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign merge_data[8*gi +: 8] = (4'(gi) < size_bytes) ? shifted[8*gi +: 8] : {8{fill_bit}};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      op_reg         <= '0;
      addr_reg       <= '0;
      tag_reg        <= '0;
      beat0_reg      <= '0;
      resp_data_reg  <= '0;
      resp_fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (req_valid) begin
          op_reg         <= req_op;
          addr_reg       <= req_addr;
          tag_reg        <= req_tag;
          resp_fault_reg <= req_illegal;
          if (req_illegal) resp_data_reg <= '0;
        end
        WAIT0: if (bus_rsp_valid) begin
          beat0_reg <= bus_rsp_data;
          if (!lat_cross) resp_data_reg <= merge_data;
        end
        WAIT1: if (bus_rsp_valid) resp_data_reg <= merge_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = req_illegal ? RESP : REQ0;
      REQ0:    if (bus_req_ready) state_next = WAIT0;
      WAIT0:   if (bus_rsp_valid) state_next = lat_cross ? REQ1 : RESP;
      REQ1:    if (bus_req_ready) state_next = WAIT1;
      WAIT1:   if (bus_rsp_valid) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = 1'b0;
    bus_req_valid = 1'b0;
    bus_addr      = '0;
    resp_valid    = 1'b0;
    case (state_reg)
      IDLE: req_ready = 1'b1;
      REQ0: begin
        bus_req_valid = 1'b1;
        bus_addr      = beat_addr;
      end
      REQ1: begin
        bus_req_valid = 1'b1;
        bus_addr      = beat_addr + XLEN'(NB);
      end
      RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_data  = resp_data_reg;
  assign resp_tag   = tag_reg;
  assign resp_fault = resp_fault_reg;

endmodule
